// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the memory request front-end.
package mem_req_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int MEM_REQ_CTRL_RSP_LATENCY = 2;

endpackage

// File: rtl/sync_mem.sv
// Single-port synchronous memory: write when writeEnable, otherwise registered read.
module sync_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             writeEnable,
  input  logic [DEPTH-1:0] address,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readData
);

  logic [WIDTH-1:0] r_mem [(1<<DEPTH)];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      r_mem[address] <= writeData;
    end else begin
      readData <= r_mem[address];
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Valid/ready request front-end for sync_mem with a one-entry read response register.
// Define MEM_REQ_CTRL_CLEAR_EN to zero the whole array after reset before accepting traffic.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [DEPTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             init_done,
  output logic             mem_writeEnable,
  output logic [DEPTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_writeData,
  input  logic [WIDTH-1:0] mem_readData
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_run;
  logic             w_accept;
  logic             w_rd_issue;
  logic             r_rd_pending;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;

  // Gating with reset keeps every output at its reset value while reset is held.
  assign w_run      = (r_state == RUN) && !reset;
  assign req_ready  = w_run && !r_rd_pending && (!r_rsp_valid || rsp_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_rd_issue = w_accept && !req_write;
  assign init_done  = w_run;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;

`ifdef MEM_REQ_CTRL_CLEAR_EN
  logic [DEPTH-1:0] r_clr_cnt;
  logic             w_clearing;

  assign w_clearing = (r_state == CLEAR) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && (r_clr_cnt == '1)) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_writeEnable = w_accept && req_write;
    mem_address     = w_accept ? req_addr  : '0;
    mem_writeData   = w_accept ? req_wdata : '0;
    if (w_clearing) begin
      mem_writeEnable = 1'b1;
      mem_address     = r_clr_cnt;
      mem_writeData   = '0;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = RUN;
  end

  always_comb begin
    mem_writeEnable = w_accept && req_write;
    mem_address     = w_accept ? req_addr  : '0;
    mem_writeData   = w_accept ? req_wdata : '0;
  end
`endif

  // Read issued in T: memory output valid in T+1, captured into the response register at its end.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_rd_pending <= w_rd_issue;
      if (r_rd_pending) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= mem_readData;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl driving a sync_mem instance.
module tb_mem_req_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
`ifdef MEM_REQ_CTRL_CLEAR_EN
  localparam int INIT_CYC = 17;
`else
  localparam int INIT_CYC = 1;
`endif

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [DEPTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             init_done;
  logic             mem_writeEnable;
  logic [DEPTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_writeData;
  logic [WIDTH-1:0] mem_readData;

  int tests;
  int fails;
  int cyc;
  logic [7:0] exp_q[$];
  int         iss_q[$];

  mem_req_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .mem_writeEnable(mem_writeEnable), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  sync_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) mem (
    .clock(clock), .writeEnable(mem_writeEnable), .address(mem_address),
    .writeData(mem_writeData), .readData(mem_readData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_req(input logic wr, input logic [3:0] a, input logic [7:0] d, output int acc);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("mem_we", mem_writeEnable, wr);
      chk("mem_addr", mem_address, a);
      chk("mem_wdata", mem_writeData, d);
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] expd, output int acc);
    do_req(1'b0, a, 8'h5A, acc);
    if (acc >= 0) begin
      exp_q.push_back(expd);
      iss_q.push_back(acc);
    end
  endtask

  task automatic wait_init(input logic hold);
    int n;
    n = 0;
    if (hold) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 8'hEE;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (init_done === 1'b1) begin
        n = i;
        break;
      end
      chk("clr_we", mem_writeEnable, 1'b1);
      chk("clr_wdata", mem_writeData, 8'h00);
      chk("clr_addr", mem_address, 32'(i - 1));
      chk("clr_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    chk("init_done_cycle", n, INIT_CYC);
    chk("ready_at_init", req_ready, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_mem_we", mem_writeEnable, 1'b0);
    chk("rst_mem_addr", mem_address, 4'h0);
  endtask

  initial begin
    int acc, acc2, prev, k;
    tests = 0; fails = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    fork
      begin : monitor
        logic held;
        int   ic;
        held = 1'b0;
        forever begin
          @(negedge clock);
          if (reset) begin
            held = 1'b0;
          end else begin
            if (rsp_valid && !held) begin
              if (iss_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
              else begin
                ic = iss_q.pop_front();
                chk("rsp_latency", cyc - ic, 32'd2);
              end
            end
            if (rsp_valid && rsp_ready) begin
              if (exp_q.size() == 0) chk("rsp_extra", 32'd1, 32'd0);
              else chk("rsp_data", rsp_data, exp_q.pop_front());
            end
            held = rsp_valid && !rsp_ready;
          end
        end
      end
    join_none

    // Power-on reset and initialisation
    @(posedge clock); @(posedge clock); @(negedge clock);
    chk_reset_outputs();
    @(posedge clock); #1 reset = 1'b0;
    wait_init(1'b0);

    // Back-to-back writes then reads, one read per two cycles
    prev = 0;
    for (int a = 0; a < 16; a++) begin
      do_req(1'b1, 4'(a), 8'(a + 16), acc);
      if (a > 0) chk("wr_rate", acc - prev, 32'd1);
      prev = acc;
    end
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), 8'(a + 16), acc);
      if (a > 0) chk("rd_rate", acc - prev, 32'd2);
      prev = acc;
    end
    repeat (4) @(posedge clock); #1;

    // Write followed immediately by a read of the same address
    do_req(1'b1, 4'd3, 8'hA5, acc);
    do_read(4'd3, 8'hA5, acc2);
    chk("wr_rd_gap", acc2 - acc, 32'd1);
    repeat (4) @(posedge clock); #1;

    // Response held under backpressure
    rsp_ready = 1'b0;
    do_read(4'd7, 8'h17, acc);
    k = 0;
    while (k < 10 && rsp_valid !== 1'b1) begin
      @(negedge clock);
      k++;
    end
    chk("stall_rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_data, 8'h17);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    chk("ready_on_rsp_ready", req_ready, 1'b1);
    @(negedge clock);
    chk("rsp_cleared", rsp_valid, 1'b0);
    @(posedge clock); #1;

    // Reset one cycle after a read accept drops the read
    do_req(1'b0, 4'd5, 8'h00, acc);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk_reset_outputs();
    @(posedge clock); #1 reset = 1'b0;
    wait_init(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("no_rsp_after_reset", rsp_valid, 1'b0);
    end
    @(posedge clock); #1;

    // Read back the whole array
    for (int a = 0; a < 16; a++) begin
`ifdef MEM_REQ_CTRL_CLEAR_EN
      do_read(4'(a), 8'h00, acc);
`else
      do_read(4'(a), (a == 3) ? 8'hA5 : 8'(a + 16), acc);
`endif
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("idle_mem_we", mem_writeEnable, 1'b0);
    chk("idle_mem_addr", mem_address, 4'h0);
    chk("idle_mem_wdata", mem_writeData, 8'h00);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("latency_q_empty", iss_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request front-end placed directly upstream of the team's single-port synchronous memory (`sync_mem`). Accepts read/write requests over a valid/ready handshake and drives the memory's `writeEnable`/`address`/`writeData` pins. It captures `readData` one cycle after a read is issued and returns it on a valid/ready response channel with a one-entry response register. Optionally clears the whole array after reset before accepting traffic.

## Interface
- `DEPTH`, default 4: address width in bits; the array has 2**DEPTH words. Must match the memory.
- `WIDTH`, default 8: data width in bits. Must match the memory.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  DEPTH  word address.
- `req_wdata`  in  WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  WIDTH  read data.
- `init_done`  out  1  high once the block accepts requests.
- `mem_writeEnable`  out  1  to memory `writeEnable`.
- `mem_address`  out  DEPTH  to memory `address`.
- `mem_writeData`  out  WIDTH  to memory `writeData`.
- `mem_readData`  in  WIDTH  from memory `readData`.

## Operation
- FSM states: `CLEAR` (only with macro), `RUN`.
- Reset always enters `CLEAR` when the macro is defined, otherwise `RUN`.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `init_done`=0, `rd_pending`=0, clear counter=0.
- Memory outputs are combinational from the accepted request: `mem_writeEnable = accept && req_write`, `mem_address = req_addr`, `mem_writeData = req_wdata`. With no accept: `mem_writeEnable`=0 and address/data are 0.
- The memory reads on every edge where `writeEnable`=0. Only the edge at which an accepted read is issued is meaningful.
- `req_ready = RUN && !rd_pending && (!rsp_valid || rsp_ready)`. The request is independent of `req_valid`/`req_write`.
- Read accepted in cycle T:
  - `rd_pending`=1 in T+1.
  - At the end of T+1, `rsp_data <= mem_readData` and `rsp_valid <= 1`. `rd_pending` clears.
- `rsp_valid` holds with `rsp_data` stable until `rsp_ready`. It clears on that edge unless a new capture happens on the same edge, in which case the new capture wins.
- Writes do not touch the response path. A write is accepted any cycle that `req_ready` is high.
- A write in T followed by a read of the same address in T+1 returns the new data.
- Reset mid-operation drops any pending read and buffered response. The clear sequence restarts from address 0.

## Timing
- Write: accepted in T, memory updated at the end of T.
- Read: accept in T, `rsp_valid` high in T+2 (latency 2).
- Peak read throughput is one read per 2 cycles (`rd_pending` blocks). It stays one read per 2 cycles with `rsp_ready` tied high.
- Peak write throughput is 1 per cycle.
- `init_done` rises in the same cycle FSM enters `RUN` and stays high until reset.

## Configuration
- `MEM_REQ_CTRL_CLEAR_EN` defined:
  - After reset, `CLEAR` drives `mem_writeEnable`=1, `mem_writeData`=0 and `mem_address` = counter, incrementing 0..2**DEPTH-1.
  - `req_ready`=0 and `init_done`=0 throughout.
  - After writing the last address (counter wrap), the FSM enters `RUN`. `init_done`=1 in cycle 2**DEPTH+1 after reset deasserts.
- Not defined: no `CLEAR` state and no counter. FSM is `RUN` the first cycle after reset deasserts, and `init_done`=1 then.

## Structure
- Package `mem_req_ctrl_pkg`: state enum typedef (`CLEAR`, `RUN`) and a `MEM_REQ_CTRL_RSP_LATENCY` = 2 constant.
- No sub-module is needed for the controller itself.
- The bench instantiates `mem_req_ctrl` and `sync_mem` together, with the memory outputs wired to the memory.

## Test plan
All scenarios use DEPTH=4, WIDTH=8.
- Write 0xA5 to addr 3 at T, read addr 3 at T+1 -> `rsp_valid` at T+3, `rsp_data`=0xA5.
- Read addr 7 with `rsp_ready`=0 for 5 cycles -> `rsp_valid`, data stable and `req_ready`=0 throughout; `rsp_ready`=1 -> `req_ready` high that same cycle.
- Back-to-back writes to addrs 0..15 with data = addr+0x10, then reads of all 16 -> each response = addr+0x10, in order, one per 2 cycles.
- With `MEM_REQ_CTRL_CLEAR_EN`: preload memory, reset, read all addresses -> all 0; `init_done` rises 17 cycles after reset release.
- Assert `reset` one cycle after a read accept -> no `rsp_valid` ever appears for that read; all outputs at reset values.
- Hold `req_valid` during the clear phase -> no memory write from the request until `init_done`=1.
